instruction_fetch_unit: RTL and testbench

Initiator side of the instruction-memory read interface. Owns the program counter, drives word addresses into the instruction memory, and captures the returned words. Buffers fetched instructions and hands them to the decode stage over a valid/ready handshake. Supports a single-cycle PC redirect from the branch, call and return logic.

---
 rtl/kgp_fetch_pkg.sv | 33 +++
 rtl/ifu_fetch_buffer.sv | 72 +++++++
 rtl/instruction_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/kgp_fetch_pkg.sv
// kgp_fetch_pkg
//   Shared definitions for the instruction fetch unit and its fetch buffer:
//   FSM state encoding, buffer depth and the buffer entry layout.
//
// Configuration macro: IFU_PREFETCH_BUF_EN
//   defined   -> two-entry prefetch buffer, sustains one instruction per cycle
//   undefined -> single holding register, one instruction every other cycle
package kgp_fetch_pkg;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } ifu_state_e;

`ifdef IFU_PREFETCH_BUF_EN
   localparam int IFU_DEPTH = 2;
`else
   localparam int IFU_DEPTH = 1;
`endif

   // Wide enough for count + in-flight, i.e. values up to IFU_DEPTH + 1.
   localparam int IFU_CNT_W = $clog2(IFU_DEPTH + 2);

   // Default instruction/address width of the entry layout.
   localparam int IFU_SIZE = 32;

   typedef struct packed {
      logic [IFU_SIZE-1:0] instr;
      logic [IFU_SIZE-1:0] pc;
   } ifu_entry_t;

endpackage

// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer
//   Circular FIFO holding fetched {instr, pc} entries between the memory
//   response and the decode handshake.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         drop every entry (wins over push and pop)
//   push_i          write push_data_i at the tail
//   push_data_i     entry to write
//   pop_i           remove the head
//   head_o          entry at the head (stale when empty)
//   count_o         number of stored entries, 0..DEPTH
//
// The owner never pushes when full nor pops when empty.
module ifu_fetch_buffer
   import kgp_fetch_pkg::*;
#(
   parameter int  DEPTH   = IFU_DEPTH,
   parameter type entry_t = ifu_entry_t
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 push_i,
   input  entry_t               push_data_i,
   input  logic                 pop_i,
   output entry_t               head_o,
   output logic [IFU_CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Storage spans the full pointer range so every pointer value is a legal
   // index; slots at or beyond DEPTH are never written.
   localparam int SLOTS = 1 << PTR_W;

   entry_t               mem_q [SLOTS];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [IFU_CNT_W-1:0] count_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + IFU_CNT_W'(push_i) - IFU_CNT_W'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Owns the program counter, issues word-address reads to a synchronous
//   instruction memory (data one cycle after the address), buffers returned
//   words and presents them to decode. A redirect pulse reloads the PC and
//   flushes everything already fetched.
//
// Configuration macro: IFU_PREFETCH_BUF_EN (buffer depth 2 when defined, 1 otherwise)
//
// Ports:
//   clka, rsta_n          clock, asynchronous active-low reset
//   addra                 word address to memory (= current PC)
//   wea, dina             memory write side, tied to zero
//   douta                 memory read data for the previous cycle's addra
//   fetch_en              allows new fetches
//   redirect_valid/_pc    one-cycle PC reload
//   out_valid/ready       decode handshake: an instruction transfers in a
//                         cycle where out_valid && out_ready are both high;
//                         out_valid does not depend on out_ready, and out_instr
//                         / out_pc stay stable while out_valid && !out_ready.
//   out_instr, out_pc     head instruction and its word address
//   dbg_state             current FSM state
module instruction_fetch_unit
   import kgp_fetch_pkg::*;
#(
   parameter int              SIZE     = 32,
   parameter logic [SIZE-1:0] RESET_PC = '0
) (
   input  logic            clka,
   input  logic            rsta_n,
   output logic [SIZE-1:0] addra,
   output logic            wea,
   output logic [SIZE-1:0] dina,
   input  logic [SIZE-1:0] douta,
   input  logic            fetch_en,
   input  logic            redirect_valid,
   input  logic [SIZE-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] out_instr,
   output logic [SIZE-1:0] out_pc,
   output ifu_state_e      dbg_state
);

   typedef struct packed {
      logic [SIZE-1:0] instr;
      logic [SIZE-1:0] pc;
   } entry_t;

   ifu_state_e           state_q, state_d;
   logic [SIZE-1:0]      pc_q, pc_d;
   logic                 inflight_q, inflight_d;
   logic [SIZE-1:0]      inflight_pc_q, inflight_pc_d;

   logic [IFU_CNT_W-1:0] buf_count;
   logic [IFU_CNT_W-1:0] occ;
   logic                 issue;
   logic                 push;
   logic                 pop;
   entry_t               head;
   entry_t               push_entry;

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q       <= RESET;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;

      // A redirect cancels the pop and the response arriving this cycle.
      // No issue happens in the redirect cycle, so nothing is in flight
      // during FLUSH.
      pop  = out_valid && out_ready && !redirect_valid;
      push = inflight_q && !redirect_valid;

      // Slots that will be committed after this cycle; an issue is allowed
      // only if its response is guaranteed a slot.
      occ   = buf_count + IFU_CNT_W'(inflight_q) - IFU_CNT_W'(pop);
      issue = fetch_en && (state_q == RUN) && !redirect_valid &&
              (occ < IFU_CNT_W'(IFU_DEPTH));
      inflight_d = issue;

      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d          = pc_q + SIZE'(1);
         inflight_pc_d = pc_q;
      end

      case (state_q)
         RESET:      state_d = RUN;
         RUN, FLUSH: state_d = redirect_valid ? FLUSH : RUN;
         default:    state_d = RESET;
      endcase

      push_entry.instr = douta;
      push_entry.pc    = inflight_pc_q;
   end

   ifu_fetch_buffer #(
      .DEPTH   (IFU_DEPTH),
      .entry_t (entry_t)
   ) u_buf (
      .clk_i       (clka),
      .rst_ni      (rsta_n),
      .clear_i     (redirect_valid),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (buf_count)
   );

   assign addra     = pc_q;
   assign wea       = 1'b0;
   assign dina      = '0;
   assign out_valid = (buf_count != '0);
   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
   import kgp_fetch_pkg::*;

   localparam int              SIZE     = 32;
   localparam logic [SIZE-1:0] RESET_PC = '0;

   logic            clka = 1'b0;
   logic            rsta_n;
   logic [SIZE-1:0] addra, dina, douta, redirect_pc, out_instr, out_pc;
   logic            wea, fetch_en, redirect_valid, out_valid, out_ready;
   ifu_state_e      dbg_state;

   int              n_cmp = 0;
   int              n_err = 0;
   logic [SIZE-1:0] exp_pc;

   // Expected addra / out_valid for cycles 1..8 after reset release.
`ifdef IFU_PREFETCH_BUF_EN
   logic [SIZE-1:0] p1_addr  [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
   logic            p1_valid [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
   localparam logic [SIZE-1:0] P1_POPS = 6;
`else
   logic [SIZE-1:0] p1_addr  [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
   logic            p1_valid [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
   localparam logic [SIZE-1:0] P1_POPS = 3;
`endif

   // clock / memory model
   always #5 clka = ~clka;

   function automatic logic [SIZE-1:0] instr_of(input logic [SIZE-1:0] a);
      return a ^ 32'hC0DE_F00D;
   endfunction

   always @(posedge clka) douta <= instr_of(addra);

   instruction_fetch_unit #(
      .SIZE     (SIZE),
      .RESET_PC (RESET_PC)
   ) dut (
      .clka           (clka),
      .rsta_n         (rsta_n),
      .addra          (addra),
      .wea            (wea),
      .dina           (dina),
      .douta          (douta),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .dbg_state      (dbg_state)
   );

   task automatic chk(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs for the current cycle are already applied; score any transfer,
   // then advance to the next falling edge.
   task automatic tick();
      if (rsta_n && out_valid && out_ready && !redirect_valid) begin
         chk("pop_pc", out_pc, exp_pc);
         chk("pop_instr", out_instr, instr_of(exp_pc));
         exp_pc = exp_pc + SIZE'(1);
      end
      @(negedge clka);
   endtask

   // Called at the falling edge where rsta_n was just released.
   task automatic run_from_reset(input string tag);
      chk({tag, "_state_c0"}, SIZE'(dbg_state), SIZE'(RESET));
      tick();
      for (int c = 0; c < 8; c++) begin
         if (c == 0) chk({tag, "_state_c1"}, SIZE'(dbg_state), SIZE'(RUN));
         chk({tag, "_addra"}, addra, p1_addr[c]);
         chk({tag, "_valid"}, SIZE'(out_valid), SIZE'(p1_valid[c]));
         tick();
      end
      chk({tag, "_pops"}, exp_pc, RESET_PC + P1_POPS);
   endtask

   initial begin
      rsta_n         = 1'b0;
      fetch_en       = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      exp_pc         = RESET_PC;
      repeat (2) @(negedge clka);

      // reset state
      chk("rst_addra", addra, RESET_PC);
      chk("rst_valid", SIZE'(out_valid), 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_wea", SIZE'(wea), 0);
      chk("rst_dina", dina, 0);
      chk("rst_state", SIZE'(dbg_state), SIZE'(RESET));

      // streaming from reset
      rsta_n = 1'b1;
      run_from_reset("p1");

      // decoder stall: address freezes exactly DEPTH words ahead of the head
      for (int i = 0; i < 6; i++) begin
         out_ready = 1'b0;
         if (i >= 2) begin
            chk("stall_addra", addra, exp_pc + SIZE'(IFU_DEPTH));
            chk("stall_valid", SIZE'(out_valid), 1);
            chk("stall_pc", out_pc, exp_pc);
         end
         tick();
      end
      out_ready = 1'b1;
      repeat (10) tick();

      // redirect to 7 with a full buffer and a same-cycle pop
      out_ready = 1'b0;
      repeat (3) tick();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 7;
      chk("rd_head_valid", SIZE'(out_valid), 1);
      tick();
      redirect_valid = 1'b0;
      exp_pc         = 7;
      chk("rd_flush_state", SIZE'(dbg_state), SIZE'(FLUSH));
      chk("rd_flush_addra", addra, 7);
      chk("rd_flush_valid", SIZE'(out_valid), 0);
      tick();
      chk("rd_r2_state", SIZE'(dbg_state), SIZE'(RUN));
      chk("rd_r2_addra", addra, 7);
      chk("rd_r2_valid", SIZE'(out_valid), 0);
      tick();
      chk("rd_r3_addra", addra, 8);
      chk("rd_r3_valid", SIZE'(out_valid), 0);
      tick();
      chk("rd_r4_valid", SIZE'(out_valid), 1);
      chk("rd_r4_pc", out_pc, 7);
      repeat (6) tick();

      // redirect mid-stream near the top of the address space (wraps)
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      exp_pc         = 32'hFFFF_FFFE;
      chk("wr_flush_state", SIZE'(dbg_state), SIZE'(FLUSH));
      repeat (2) tick();
      chk("wr_r3_addra", addra, 32'hFFFF_FFFF);
      tick();
      chk("wr_r4_valid", SIZE'(out_valid), 1);
      repeat (10) tick();
      chk("wr_wrapped", SIZE'(exp_pc < 32'h10), 1);

      // fetch_en dropped: in-flight word drains, address stops
      fetch_en = 1'b0;
      repeat (4) tick();
      chk("fe_valid", SIZE'(out_valid), 0);
      chk("fe_addra", addra, exp_pc);
      tick();
      chk("fe_addra_hold", addra, exp_pc);
      fetch_en = 1'b1;
      repeat (6) tick();

      // reset while the buffer is full
      out_ready = 1'b0;
      repeat (4) tick();
      chk("rf_pre_valid", SIZE'(out_valid), 1);
      #2 rsta_n = 1'b0;
      #1;
      chk("rf_valid", SIZE'(out_valid), 0);
      chk("rf_addra", addra, RESET_PC);
      chk("rf_pc", out_pc, 0);
      chk("rf_instr", out_instr, 0);
      chk("rf_state", SIZE'(dbg_state), SIZE'(RESET));
      @(negedge clka);
      rsta_n    = 1'b1;
      out_ready = 1'b1;
      exp_pc    = RESET_PC;
      run_from_reset("p5");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
